// File: rtl/bcd_time_counter.sv
// Parametrised BCD time-of-day counter: FIELDS two-digit BCD fields, up/down on tick,
// validated parallel load, top-field limit, countdown expire and alarm-match pulses.
module bcd_time_counter #(
  parameter int         FIELDS    = 2,
  parameter logic [7:0] TOP_LIMIT = 8'h59,
  parameter logic [7:0] SUB_LIMIT = 8'h59
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  stop_at_zero,
  input  logic                  load,
  input  logic [8*FIELDS-1:0]   load_value,
  input  logic [8*FIELDS-1:0]   alarm_time,
  input  logic                  alarm_en,
  output logic [8*FIELDS-1:0]   current_time,
  output logic                  wrap,
  output logic                  expired,
  output logic                  alarm_match,
  output logic                  load_err
);

  localparam int W = 8 * FIELDS;

  logic [W-1:0] up_val;
  logic [W-1:0] down_val;
  logic         up_wrap;
  logic         down_wrap;
  logic         load_ok;
  logic         at_zero;
  logic         carry;
  logic         borrow;
  logic [7:0]   fld;
  logic [7:0]   lim;

  always_comb begin
    up_val   = current_time;
    down_val = current_time;
    carry    = 1'b1;
    borrow   = 1'b1;
    load_ok  = 1'b1;
    fld      = 8'h00;
    lim      = 8'h00;
    at_zero  = (current_time == '0);

    // Up: ripple the carry through fields; a field at its limit rolls to 00.
    for (int i = 0; i < FIELDS; i++) begin
      fld = current_time[8*i +: 8];
      lim = (i == FIELDS - 1) ? TOP_LIMIT : SUB_LIMIT;
      if (carry) begin
        if (fld == lim) begin
          up_val[8*i +: 8] = 8'h00;
        end else begin
          carry = 1'b0;
          if (fld[3:0] == 4'd9) up_val[8*i +: 8] = {fld[7:4] + 4'd1, 4'd0};
          else                  up_val[8*i +: 8] = {fld[7:4], fld[3:0] + 4'd1};
        end
      end
    end

    // Down: ripple the borrow; a field at 00 reloads its limit.
    for (int i = 0; i < FIELDS; i++) begin
      fld = current_time[8*i +: 8];
      lim = (i == FIELDS - 1) ? TOP_LIMIT : SUB_LIMIT;
      if (borrow) begin
        if (fld == 8'h00) begin
          down_val[8*i +: 8] = lim;
        end else begin
          borrow = 1'b0;
          if (fld[3:0] == 4'd0) down_val[8*i +: 8] = {fld[7:4] - 4'd1, 4'd9};
          else                  down_val[8*i +: 8] = {fld[7:4], fld[3:0] - 4'd1};
        end
      end
    end

    // Nibbles are checked first, so a plain byte compare orders BCD correctly.
    for (int i = 0; i < FIELDS; i++) begin
      fld = load_value[8*i +: 8];
      lim = (i == FIELDS - 1) ? TOP_LIMIT : SUB_LIMIT;
      if (fld[3:0] > 4'd9 || fld[7:4] > 4'd9 || fld > lim) load_ok = 1'b0;
    end

    up_wrap   = carry;
    down_wrap = borrow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_time <= '0;
      wrap         <= 1'b0;
      expired      <= 1'b0;
      alarm_match  <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      wrap        <= 1'b0;
      expired     <= 1'b0;
      alarm_match <= 1'b0;
      load_err    <= 1'b0;
      if (load) begin
        if (load_ok) begin
          current_time <= load_value;
          alarm_match  <= alarm_en && (load_value == alarm_time);
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick && run) begin
        if (!dir) begin
          current_time <= up_val;
          wrap         <= up_wrap;
          alarm_match  <= alarm_en && (up_val == alarm_time);
        end else if (!(stop_at_zero && at_zero)) begin
          current_time <= down_val;
          wrap         <= down_wrap;
          expired      <= stop_at_zero && (down_val == '0);
          alarm_match  <= alarm_en && (down_val == alarm_time);
        end
      end
    end
  end

endmodule
